control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter OPW, default 5, opcode width taken from ir[31:32-OPW].
REQ-002 Parameter WAIT_MAX, default 15, maximum mem_ready wait cycles before bus error.
REQ-003 Parameter CNT_W, default 16, width of instr_count.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 clr  input  1  reset, synchronous, active-high.
REQ-006 run  input  1  permit instruction fetch.
REQ-007 ir  input  32  instruction register contents; valid from T4.
REQ-008 mem_ready  input  1  memory read data valid.
REQ-009 Strobe outputs, each 1 bit: PCout, Zlowout, Zhighout, MDRout, HIout, LOout, Rout, MARIn, PCIn, MDRIn, IRIn, YIn, ZIn, IncPC, HiIn, LoIn, RIn, Gra, Grb, Grc, read, write.
REQ-010 alu_op  output  3  000 none, 001 add, 010 sub, 011 and, 100 or, 101 mul, 110 div.
REQ-011 t_step  output  4  0-7 = T0-T7, 8 = IDLE, 9 = HALT.
REQ-012 halted, illegal, bus_err  output  1 each  sticky status flags.
REQ-013 instr_count  output  CNT_W  completed-instruction counter.

Function
REQ-014 Strobes, alu_op and t_step SHALL be Moore outputs of registered state (plus ir in T4); strobes not listed for a step are 0; write is always 0.
REQ-015 IDLE: no strobes; go to T0 when run=1, else stay.
REQ-016 T0: PCout, MARIn, IncPC, ZIn; go to T1.
REQ-017 T1: Zlowout, PCIn; go to T2.
REQ-018 T2: read, MDRIn held every cycle; go to T3 on the cycle mem_ready=1; wait counter increments each cycle with mem_ready=0.
REQ-019 T2 with wait counter = WAIT_MAX and mem_ready=0: set bus_err, go to HALT.
REQ-020 T3: MDRout, IRIn; go to T4; wait counter cleared.
REQ-021 Opcodes (OPW=5): add 00011, sub 00100, and 00101, or 00110, mul 01110, div 01111, mfhi 11000, mflo 11001, nop 11010, halt 11011.
REQ-022 T4 strobes decode ir opcode combinationally; opcode latched into internal op register at end of T4 and used in T5-T7.
REQ-023 add/sub/and/or: T4 Grb, Rout, YIn; T5 Grc, Rout, ZIn, alu_op per op; T6 Zlowout, Gra, RIn; then end-of-instruction.
REQ-024 mul/div: T4 Gra, Rout, YIn; T5 Grb, Rout, ZIn, alu_op 101/110; T6 Zlowout, LoIn; T7 Zhighout, HiIn; then end-of-instruction.
REQ-025 mfhi: T4 Gra, RIn, HIout; mflo: T4 Gra, RIn, LOout; nop: T4 no strobes; each then end-of-instruction.
REQ-026 halt opcode: T4 no strobes, then HALT with halted=1.
REQ-027 Undefined opcode: T4 no strobes, then HALT with illegal=1 and halted=1.
REQ-028 End-of-instruction: instr_count increments (wraps all-ones to 0); next state T0 if run=1, IDLE if run=0.
REQ-029 run is sampled only in IDLE and at end-of-instruction; run=0 mid-instruction does not abort it.
REQ-030 HALT: no strobes, t_step=9, held until clr; flags sticky until clr.

Reset
REQ-031 clr=1 at a rising edge SHALL, regardless of state including mid-T2 wait or HALT, set state IDLE, all strobes 0, alu_op 000, t_step 8, halted/illegal/bus_err 0, instr_count 0, wait counter 0, op register 0.
REQ-032 clr has priority over run and mem_ready in the same cycle.

Verification
REQ-033 clr, run=1, mem_ready=1, ir[31:27]=11000 -> t_step 0,1,2,3,4,0; T4 shows Gra=RIn=HIout=1; instr_count=1 after T4.
REQ-034 ir opcode 01110, mem_ready=1 -> 8-cycle instruction; T5 alu_op=101 with ZIn=1; T6 Zlowout=LoIn=1; T7 Zhighout=HiIn=1; instr_count+1.
REQ-035 mem_ready=0 for 3 cycles in T2 -> T2 lasts 4 cycles with read=MDRIn=1 throughout, then T3 with MDRout=IRIn=1.
REQ-036 mem_ready stuck 0, WAIT_MAX=15 -> 16 cycles in T2, then t_step=9, bus_err=1, halted=1; clr -> IDLE, flags 0.
REQ-037 ir opcode 11111 -> HALT after T4 with illegal=1; opcode 11011 -> HALT with illegal=0, halted=1.
REQ-038 run dropped during T5 of add -> T6 completes with Gra=RIn=1, then IDLE; clr asserted in T5 -> IDLE next cycle, no T6 strobes; instr_count at all-ones wraps to 0 on next completion.

Source files
------------

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: steps T0-T7 fetch/decode/execute, producing
// datapath strobes, an ALU opcode and sticky status flags.
module control_sequencer #(
  parameter int unsigned OPW      = 5,
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  input  logic [31:0]      ir,
  input  logic             mem_ready,
  output logic             PCout,
  output logic             Zlowout,
  output logic             Zhighout,
  output logic             MDRout,
  output logic             HIout,
  output logic             LOout,
  output logic             Rout,
  output logic             MARIn,
  output logic             PCIn,
  output logic             MDRIn,
  output logic             IRIn,
  output logic             YIn,
  output logic             ZIn,
  output logic             IncPC,
  output logic             HiIn,
  output logic             LoIn,
  output logic             RIn,
  output logic             Gra,
  output logic             Grb,
  output logic             Grc,
  output logic             read,
  output logic             write,
  output logic [2:0]       alu_op,
  output logic [3:0]       t_step,
  output logic             halted,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] instr_count
);

  // State codes equal the t_step value so the step output is the state itself.
  localparam logic [3:0] S_T0   = 4'd0;
  localparam logic [3:0] S_T1   = 4'd1;
  localparam logic [3:0] S_T2   = 4'd2;
  localparam logic [3:0] S_T3   = 4'd3;
  localparam logic [3:0] S_T4   = 4'd4;
  localparam logic [3:0] S_T5   = 4'd5;
  localparam logic [3:0] S_T6   = 4'd6;
  localparam logic [3:0] S_T7   = 4'd7;
  localparam logic [3:0] S_IDLE = 4'd8;
  localparam logic [3:0] S_HALT = 4'd9;

  localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
  localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00101);
  localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00110);
  localparam logic [OPW-1:0] OP_MUL  = OPW'(5'b01110);
  localparam logic [OPW-1:0] OP_DIV  = OPW'(5'b01111);
  localparam logic [OPW-1:0] OP_MFHI = OPW'(5'b11000);
  localparam logic [OPW-1:0] OP_MFLO = OPW'(5'b11001);
  localparam logic [OPW-1:0] OP_NOP  = OPW'(5'b11010);
  localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

  localparam int unsigned WW = $clog2(WAIT_MAX + 2);
  localparam logic [WW-1:0] WAIT_LIM = WW'(WAIT_MAX);

  logic [3:0]     state, state_nx;
  logic [OPW-1:0] op_q;
  logic [OPW-1:0] opcode, cur_op;
  logic [WW-1:0]  wait_cnt;
  logic           is_alu, is_md, is_move, is_halt, eoi, wait_expired;
  logic           unused_ir;

  assign opcode    = ir[31 -: OPW];
  assign unused_ir = ^ir;
  // T4 decodes the live ir; later steps use the opcode captured at end of T4.
  assign cur_op    = (state == S_T4) ? opcode : op_q;
  assign is_alu    = (cur_op == OP_ADD) || (cur_op == OP_SUB) ||
                     (cur_op == OP_AND) || (cur_op == OP_OR);
  assign is_md     = (cur_op == OP_MUL) || (cur_op == OP_DIV);
  assign is_move   = (cur_op == OP_MFHI) || (cur_op == OP_MFLO) || (cur_op == OP_NOP);
  assign is_halt   = (cur_op == OP_HALT);
  assign t_step    = state;

  // mem_ready handshake: read/MDRIn are held in T2 until mem_ready=1 is seen
  // at a rising edge; that edge moves to T3. A bounded wait ends in bus error.
  assign wait_expired = (state == S_T2) && !mem_ready && (wait_cnt == WAIT_LIM);

  always_comb begin
    state_nx = state;
    eoi      = 1'b0;
    case (state)
      S_IDLE: if (run) state_nx = S_T0;
      S_T0:   state_nx = S_T1;
      S_T1:   state_nx = S_T2;
      S_T2: begin
        if (mem_ready)         state_nx = S_T3;
        else if (wait_expired) state_nx = S_HALT;
      end
      S_T3:   state_nx = S_T4;
      S_T4: begin
        if (is_alu || is_md) state_nx = S_T5;
        else if (is_move)    eoi = 1'b1;
        else                 state_nx = S_HALT;
      end
      S_T5:   state_nx = S_T6;
      S_T6: begin
        if (is_md) state_nx = S_T7;
        else       eoi = 1'b1;
      end
      S_T7:   eoi = 1'b1;
      S_HALT: state_nx = S_HALT;
      default: state_nx = S_IDLE;
    endcase
    if (eoi) state_nx = run ? S_T0 : S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= S_IDLE;
      op_q        <= '0;
      wait_cnt    <= '0;
      halted      <= 1'b0;
      illegal     <= 1'b0;
      bus_err     <= 1'b0;
      instr_count <= '0;
    end else begin
      state <= state_nx;
      if (state == S_T2 && !mem_ready && !wait_expired) wait_cnt <= wait_cnt + WW'(1);
      if (state == S_T3) wait_cnt <= '0;
      if (state == S_T4) op_q <= opcode;
      if (eoi) instr_count <= instr_count + CNT_W'(1);
      if (wait_expired) begin
        bus_err <= 1'b1;
        halted  <= 1'b1;
      end
      if (state == S_T4 && !is_alu && !is_md && !is_move) begin
        halted <= 1'b1;
        if (!is_halt) illegal <= 1'b1;
      end
    end
  end

  always_comb begin
    {PCout, Zlowout, Zhighout, MDRout, HIout, LOout, Rout, MARIn, PCIn, MDRIn,
     IRIn, YIn, ZIn, IncPC, HiIn, LoIn, RIn, Gra, Grb, Grc, read, write} = '0;
    alu_op = 3'b000;
    case (state)
      S_T0: begin PCout = 1'b1; MARIn = 1'b1; IncPC = 1'b1; ZIn = 1'b1; end
      S_T1: begin Zlowout = 1'b1; PCIn = 1'b1; end
      S_T2: begin read = 1'b1; MDRIn = 1'b1; end
      S_T3: begin MDRout = 1'b1; IRIn = 1'b1; end
      S_T4: begin
        if (is_alu) begin Grb = 1'b1; Rout = 1'b1; YIn = 1'b1; end
        if (is_md)  begin Gra = 1'b1; Rout = 1'b1; YIn = 1'b1; end
        if (cur_op == OP_MFHI) begin Gra = 1'b1; RIn = 1'b1; HIout = 1'b1; end
        if (cur_op == OP_MFLO) begin Gra = 1'b1; RIn = 1'b1; LOout = 1'b1; end
      end
      S_T5: begin
        Rout = 1'b1;
        ZIn  = 1'b1;
        if (is_md) Grb = 1'b1;
        else       Grc = 1'b1;
        case (cur_op)
          OP_ADD:  alu_op = 3'b001;
          OP_SUB:  alu_op = 3'b010;
          OP_AND:  alu_op = 3'b011;
          OP_OR:   alu_op = 3'b100;
          OP_MUL:  alu_op = 3'b101;
          OP_DIV:  alu_op = 3'b110;
          default: alu_op = 3'b000;
        endcase
      end
      S_T6: begin
        Zlowout = 1'b1;
        if (is_md) LoIn = 1'b1;
        else begin Gra = 1'b1; RIn = 1'b1; end
      end
      S_T7: begin Zhighout = 1'b1; HiIn = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench: a transaction-level model expands each instruction into
// its expected per-cycle step/strobe trace, which is replayed against the DUT.
module tb_control_sequencer;

  localparam int TB_CNT_W = 8;

  localparam logic [21:0] B_PCOUT    = 22'd1 << 21;
  localparam logic [21:0] B_ZLOWOUT  = 22'd1 << 20;
  localparam logic [21:0] B_ZHIGHOUT = 22'd1 << 19;
  localparam logic [21:0] B_MDROUT   = 22'd1 << 18;
  localparam logic [21:0] B_HIOUT    = 22'd1 << 17;
  localparam logic [21:0] B_LOOUT    = 22'd1 << 16;
  localparam logic [21:0] B_ROUT     = 22'd1 << 15;
  localparam logic [21:0] B_MARIN    = 22'd1 << 14;
  localparam logic [21:0] B_PCIN     = 22'd1 << 13;
  localparam logic [21:0] B_MDRIN    = 22'd1 << 12;
  localparam logic [21:0] B_IRIN     = 22'd1 << 11;
  localparam logic [21:0] B_YIN      = 22'd1 << 10;
  localparam logic [21:0] B_ZIN      = 22'd1 << 9;
  localparam logic [21:0] B_INCPC    = 22'd1 << 8;
  localparam logic [21:0] B_HIIN     = 22'd1 << 7;
  localparam logic [21:0] B_LOIN     = 22'd1 << 6;
  localparam logic [21:0] B_RIN      = 22'd1 << 5;
  localparam logic [21:0] B_GRA      = 22'd1 << 4;
  localparam logic [21:0] B_GRB      = 22'd1 << 3;
  localparam logic [21:0] B_GRC      = 22'd1 << 2;
  localparam logic [21:0] B_READ     = 22'd1 << 1;

  localparam logic [4:0] OP_ADD = 5'b00011, OP_SUB = 5'b00100, OP_AND = 5'b00101,
                         OP_OR = 5'b00110, OP_MUL = 5'b01110, OP_DIV = 5'b01111,
                         OP_MFHI = 5'b11000, OP_MFLO = 5'b11001, OP_NOP = 5'b11010,
                         OP_HALT = 5'b11011;

  logic clk = 1'b0;
  logic clr, run, mem_ready;
  logic [31:0] ir;
  logic PCout, Zlowout, Zhighout, MDRout, HIout, LOout, Rout, MARIn, PCIn, MDRIn,
        IRIn, YIn, ZIn, IncPC, HiIn, LoIn, RIn, Gra, Grb, Grc, read, write;
  logic [2:0] alu_op;
  logic [3:0] t_step;
  logic halted, illegal, bus_err;
  logic [TB_CNT_W-1:0] instr_count;

  control_sequencer #(.OPW(5), .WAIT_MAX(15), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .clr(clr), .run(run), .ir(ir), .mem_ready(mem_ready),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .Rout(Rout), .MARIn(MARIn), .PCIn(PCIn),
    .MDRIn(MDRIn), .IRIn(IRIn), .YIn(YIn), .ZIn(ZIn), .IncPC(IncPC),
    .HiIn(HiIn), .LoIn(LoIn), .RIn(RIn), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .read(read), .write(write), .alu_op(alu_op), .t_step(t_step),
    .halted(halted), .illegal(illegal), .bus_err(bus_err),
    .instr_count(instr_count)
  );

  // Clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic        run;
    logic        mr;
    logic        clr;
    logic [31:0] ir;
  } stim_t;

  stim_t       stim_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] cnt_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model status
  bit m_halted = 0, m_ill = 0, m_bus = 0;
  int m_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic r, input logic m, input logic [31:0] irv,
                      input logic [3:0] st, input logic [2:0] al, input logic [21:0] sb);
    stim_t s;
    s.run = r; s.mr = m; s.clr = 1'b0; s.ir = irv;
    stim_q.push_back(s);
    exp_q.push_back({st, al, sb, logic'(m_halted), logic'(m_ill), logic'(m_bus)});
    cnt_q.push_back(32'(m_cnt));
  endtask

  // clr rides on the most recently queued cycle; everything after starts clean.
  task automatic apply_clr();
    stim_t s;
    s = stim_q.pop_back();
    s.clr = 1'b1;
    stim_q.push_back(s);
    m_halted = 0; m_ill = 0; m_bus = 0; m_cnt = 0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) push(1'b0, rb(), $urandom, 4'd8, 3'd0, 22'd0);
    push(1'b1, rb(), $urandom, 4'd8, 3'd0, 22'd0);
  endtask

  task automatic halt_cycles(input int n);
    for (int i = 0; i < n; i++) push(rb(), rb(), $urandom, 4'd9, 3'd0, 22'd0);
  endtask

  // One instruction from T0; waits>=16 models a stuck bus; stop>=0 truncates after that step.
  task automatic instr(input logic [4:0] op, input int waits, input logic run_next, input int stop);
    logic [31:0] irv;
    logic [3:0]  st[4];
    logic [2:0]  al[4];
    logic [21:0] sb[4];
    int n;
    bit ends;
    irv = {op, 27'($urandom)};
    push(rb(), rb(), irv, 4'd0, 3'd0, B_PCOUT | B_MARIN | B_INCPC | B_ZIN);
    if (stop == 0) return;
    push(rb(), rb(), irv, 4'd1, 3'd0, B_ZLOWOUT | B_PCIN);
    if (stop == 1) return;
    for (int i = 0; i < waits && i < 16; i++) begin
      push(rb(), 1'b0, irv, 4'd2, 3'd0, B_READ | B_MDRIN);
      if (stop == 2) return;
    end
    if (waits >= 16) begin
      m_bus = 1; m_halted = 1;
      return;
    end
    push(rb(), 1'b1, irv, 4'd2, 3'd0, B_READ | B_MDRIN);
    if (stop == 2) return;
    push(rb(), rb(), irv, 4'd3, 3'd0, B_MDROUT | B_IRIN);
    if (stop == 3) return;
    n = 1; ends = 1;
    st[0] = 4'd4; al[0] = 3'd0; sb[0] = 22'd0;
    for (int i = 1; i < 4; i++) begin st[i] = 4'd0; al[i] = 3'd0; sb[i] = 22'd0; end
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        sb[0] = B_GRB | B_ROUT | B_YIN;
        st[1] = 4'd5; sb[1] = B_GRC | B_ROUT | B_ZIN;
        al[1] = (op == OP_ADD) ? 3'd1 : (op == OP_SUB) ? 3'd2 : (op == OP_AND) ? 3'd3 : 3'd4;
        st[2] = 4'd6; sb[2] = B_ZLOWOUT | B_GRA | B_RIN;
        n = 3;
      end
      OP_MUL, OP_DIV: begin
        sb[0] = B_GRA | B_ROUT | B_YIN;
        st[1] = 4'd5; sb[1] = B_GRB | B_ROUT | B_ZIN;
        al[1] = (op == OP_MUL) ? 3'd5 : 3'd6;
        st[2] = 4'd6; sb[2] = B_ZLOWOUT | B_LOIN;
        st[3] = 4'd7; sb[3] = B_ZHIGHOUT | B_HIIN;
        n = 4;
      end
      OP_MFHI: sb[0] = B_GRA | B_RIN | B_HIOUT;
      OP_MFLO: sb[0] = B_GRA | B_RIN | B_LOOUT;
      OP_NOP:  sb[0] = 22'd0;
      default: ends = 0;
    endcase
    for (int i = 0; i < n; i++) begin
      push((i == n - 1 && ends) ? run_next : rb(), rb(), irv, st[i], al[i], sb[i]);
      if (int'(st[i]) == stop) return;
    end
    if (ends) m_cnt = (m_cnt + 1) % (1 << TB_CNT_W);
    else begin
      m_halted = 1;
      if (op != OP_HALT) m_ill = 1;
    end
  endtask

  function automatic logic [31:0] observed();
    return {t_step, alu_op,
            PCout, Zlowout, Zhighout, MDRout, HIout, LOout, Rout, MARIn, PCIn, MDRIn,
            IRIn, YIn, ZIn, IncPC, HiIn, LoIn, RIn, Gra, Grb, Grc, read, write,
            halted, illegal, bus_err};
  endfunction

  logic [4:0] rand_ops[8];

  initial begin
    logic [4:0] op;
    logic rn;
    stim_t s;
    rand_ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, OP_DIV, OP_MFHI, OP_MFLO};

    // Directed scenarios first, then random instructions past the counter wrap.
    idle_cycles(2);
    instr(OP_MFHI, 0, 1'b1, -1);
    instr(OP_MUL, 0, 1'b1, -1);
    instr(OP_ADD, 3, 1'b0, -1);
    idle_cycles(1);
    instr(OP_NOP, 0, 1'b1, -1);
    instr(OP_ADD, 0, 1'b1, 5);
    apply_clr();
    idle_cycles(1);
    instr(OP_DIV, 16, 1'b1, -1);
    halt_cycles(3);
    apply_clr();
    idle_cycles(0);
    instr(5'b11111, 0, 1'b1, -1);
    halt_cycles(2);
    apply_clr();
    idle_cycles(0);
    instr(OP_HALT, 0, 1'b1, -1);
    halt_cycles(2);
    apply_clr();
    idle_cycles(0);
    instr(OP_SUB, 2, 1'b1, 2);
    apply_clr();
    idle_cycles(0);
    repeat (300) begin
      op = rand_ops[$urandom_range(0, 7)];
      rn = rb();
      instr(op, $urandom_range(0, 5), rn, -1);
      if (!rn) idle_cycles($urandom_range(0, 2));
    end
    instr(OP_OR, 1, 1'b0, -1);
    push(1'b0, 1'b0, 32'd0, 4'd8, 3'd0, 22'd0);
    push(1'b0, 1'b0, 32'd0, 4'd8, 3'd0, 22'd0);

    clr = 1'b1; run = 1'b0; mem_ready = 1'b0; ir = 32'd0;
    repeat (2) @(posedge clk);

    // Driver + scoreboard: check the state reached, then drive the next inputs.
    for (int k = 0; stim_q.size() > 0; k++) begin
      @(negedge clk);
      check($sformatf("obs@%0d", k), observed(), exp_q.pop_front());
      check($sformatf("count@%0d", k), 32'(instr_count), cnt_q.pop_front());
      s = stim_q.pop_front();
      clr = s.clr; run = s.run; mem_ready = s.mr; ir = s.ir;
    end
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
